display_scheduler: RTL and testbench
====================================

# display_scheduler

Sequences the tracker's four metric registers (total steps, distance, seconds over 32 steps/s, high-activity seconds) onto the shared 4-digit BCD display. It owns one iterative binary-to-BCD converter and time-shares it, converting only the active mode's source. It also runs the rotation state machine, either auto-advancing on a 2 s tick or following a manual selection. It sits between the metric counters and the seven-segment driver and replaces the free-running combinational divide/modulo display path.

## Interface
- W, 31: width of every metric input.
- MAX_DISP, 9999: saturation limit for 4-digit modes.
- BLANK, 5'h1F: digit code the segment driver renders as "_".
- sys_clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- step_count  in  W  total steps (mode 0).
- half_miles  in  W  distance in half-mile units; bit 0 is the fraction (mode 1).
- over32_secs  in  W  seconds with more than 32 steps (mode 2).
- high_act_secs  in  W  high-activity seconds (mode 3).
- rot_tick  in  1  one-sys_clk pulse every 2 s, already synchronized.
- hold  in  1  1 = manual mode from sel; 0 = auto-rotate.
- sel  in  2  manual mode select.
- bcd3, bcd2, bcd1, bcd0  out  5 each  display digits; bcd3 is most significant.
- disp_mode  out  2  mode of the frame currently on bcd*.
- frame_valid  out  1  one-cycle pulse when a new frame is committed.
- sat  out  1  current frame was clamped.
- si  out  1  registered (step_count > MAX_DISP), updated every cycle.

## Operation
- Mode register mode_q:
  - With hold=0, each rot_tick advances 0→1→2→3→0.
  - With hold=1, mode_q loads sel every cycle and rot_tick is ignored.
- FSM states: IDLE, LOAD, CONVERT, COMMIT.
  - IDLE → LOAD unconditionally. IDLE is entered only from reset.
  - LOAD: snapshot the source selected by mode_q, clamp it, capture mode_q into mode_snap, clear the BCD shift register and iteration count. → CONVERT.
  - CONVERT: one shift-add-3 (double-dabble) step per cycle on a 14-bit operand with a 16-bit BCD accumulator. Exactly 14 cycles. → COMMIT.
  - COMMIT: write bcd*, disp_mode ← mode_snap, sat, frame_valid ← 1. → LOAD, so conversion repeats back-to-back and tracks live counts.
- Clamp and format rules:
  - Modes 0, 2, 3: value > MAX_DISP converts as 9999 and sets sat=1. Output digits are the four BCD digits.
  - Mode 1: operand is half_miles >> 1, clamped to 99 (sat=1 if clamped).
    - bcd3 = tens digit, bcd2 = units digit, bcd1 = BLANK.
    - bcd0 = 5 if the snapshotted half_miles[0]=1, else 0.
- Abort on mode change: if mode_q changes while the FSM is in CONVERT, the conversion is discarded and the next state is LOAD. bcd*, disp_mode and sat keep the previous frame. No partial frame is ever visible.
- Mode change during LOAD or COMMIT: that frame completes with mode_snap, and the following LOAD picks up the new mode.
- bcd* and disp_mode change only in COMMIT. frame_valid is high exactly one cycle per commit.

## Timing
- Reset values: bcd3..bcd0=0, disp_mode=0, frame_valid=0, sat=0, si=0, mode_q=0, FSM=IDLE.
- Frame sequence after reset release (first cycle = cycle 0):
  - Cycle 0: IDLE.
  - Cycle 1: LOAD.
  - Cycles 2–15: CONVERT.
  - Cycle 16: COMMIT.
  - Outputs and frame_valid=1 visible in cycle 17.
- Steady-state refresh period: 16 cycles (LOAD + 14 CONVERT + COMMIT).
- Latency from a rot_tick sampled during CONVERT to a frame for the new mode: at most 17 cycles (abort edge, then a full frame).
- rot_tick coincident with COMMIT: the old frame commits with the old disp_mode, and the new mode is loaded in the next cycle.
- Reset asserted in any state: all registers take reset values at that edge. Any frame in progress is lost.
- si has one-cycle latency from step_count and is independent of mode and FSM.
- mode_q wraps 3→0. Source values are sampled only at LOAD, so changes during CONVERT do not affect the current frame.

## Test plan
- Reset, step_count=1234, hold=1, sel=0 → cycle 17: bcd=1,2,3,4; disp_mode=0; sat=0; frame_valid pulses once; then every 16 cycles.
- step_count=12000 → bcd=9,9,9,9; sat=1; si=1 one cycle after the input is applied.
- hold=1, sel=1, half_miles=15 → bcd=0,7,1F,5. Then half_miles=400 → 9,9,1F,0 with sat=1.
- hold=0, rot_tick pulsed four times with each pulse landing mid-CONVERT → disp_mode steps 1,2,3,0. Each new frame appears at most 17 cycles after its tick, and bcd never changes outside a frame_valid pulse.
- rot_tick on the COMMIT cycle → committed disp_mode equals the old mode; the next frame shows the new mode 16 cycles later.
- Reset asserted mid-CONVERT with bcd=5,6,7,8 showing → next cycle all outputs 0; the first new frame appears 17 cycles after release.

Source files
------------

// File: rtl/display_scheduler.sv
// Time-shares one double-dabble converter across the four metric
// registers and rotates them onto the 4-digit BCD display.
module display_scheduler #(
  parameter int         W        = 31,
  parameter int         MAX_DISP = 9999,
  parameter logic [4:0] BLANK    = 5'h1F
) (
  input  logic         sys_clk,
  input  logic         reset,
  input  logic [W-1:0] step_count,
  input  logic [W-1:0] half_miles,
  input  logic [W-1:0] over32_secs,
  input  logic [W-1:0] high_act_secs,
  input  logic         rot_tick,
  input  logic         hold,
  input  logic [1:0]   sel,
  output logic [4:0]   bcd3,
  output logic [4:0]   bcd2,
  output logic [4:0]   bcd1,
  output logic [4:0]   bcd0,
  output logic [1:0]   disp_mode,
  output logic         frame_valid,
  output logic         sat,
  output logic         si
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CONVERT,
    COMMIT
  } state_t;

  localparam logic [W-1:0] MAX_W  = W'(MAX_DISP);
  localparam logic [W-1:0] DIST_W = W'(99);

  state_t       state;
  logic [1:0]   mode_q;
  logic [1:0]   mode_snap;
  logic [1:0]   mode_nxt;
  logic [13:0]  bin_q;
  logic [15:0]  bcd_q;
  logic [3:0]   cnt_q;
  logic         sat_snap;
  logic         frac_snap;
  logic [W-1:0] src;
  logic         clamp;
  logic [13:0]  operand;
  logic [14:0]  adj;

  always_comb begin
    mode_nxt = mode_q;
    if (hold)
      mode_nxt = sel;
    else if (rot_tick)
      mode_nxt = mode_q + 2'd1;
  end

  always_comb begin
    src = step_count;
    unique case (mode_q)
      2'd0: src = step_count;
      2'd1: src = half_miles >> 1;
      2'd2: src = over32_secs;
      2'd3: src = high_act_secs;
    endcase
    clamp   = (mode_q == 2'd1) ? (src > DIST_W)
                               : (src > MAX_W);
    operand = src[13:0];
    if (clamp)
      operand = (mode_q == 2'd1) ? 14'd99
                                 : 14'(MAX_DISP);
  end

  // Top digit is at most 4 before its final shift, so it never needs +3.
  always_comb begin
    adj = bcd_q[14:0];
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= 2'd0;
      mode_snap   <= 2'd0;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      sat_snap    <= 1'b0;
      frac_snap   <= 1'b0;
      bcd3        <= '0;
      bcd2        <= '0;
      bcd1        <= '0;
      bcd0        <= '0;
      disp_mode   <= 2'd0;
      frame_valid <= 1'b0;
      sat         <= 1'b0;
      si          <= 1'b0;
    end else begin
      si          <= step_count > MAX_W;
      mode_q      <= mode_nxt;
      frame_valid <= 1'b0;
      unique case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          bin_q     <= operand;
          bcd_q     <= '0;
          cnt_q     <= '0;
          mode_snap <= mode_q;
          sat_snap  <= clamp;
          frac_snap <= half_miles[0];
          state     <= CONVERT;
        end
        CONVERT: begin
          if (mode_nxt != mode_q) begin
            state <= LOAD;
          end else begin
            bcd_q <= {adj, bin_q[13]};
            bin_q <= {bin_q[12:0], 1'b0};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd13)
              state <= COMMIT;
          end
        end
        COMMIT: begin
          if (mode_snap == 2'd1) begin
            bcd3 <= {1'b0, bcd_q[7:4]};
            bcd2 <= {1'b0, bcd_q[3:0]};
            bcd1 <= BLANK;
            bcd0 <= frac_snap ? 5'd5 : 5'd0;
          end else begin
            bcd3 <= {1'b0, bcd_q[15:12]};
            bcd2 <= {1'b0, bcd_q[11:8]};
            bcd1 <= {1'b0, bcd_q[7:4]};
            bcd0 <= {1'b0, bcd_q[3:0]};
          end
          disp_mode   <= mode_snap;
          sat         <= sat_snap;
          frame_valid <= 1'b1;
          state       <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with a frame scoreboard
// and an always-on output-stability monitor.
module tb_display_scheduler;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [30:0] step_count;
  logic [30:0] half_miles;
  logic [30:0] over32_secs;
  logic [30:0] high_act_secs;
  logic        rot_tick;
  logic        hold;
  logic [1:0]  sel;
  logic [4:0]  bcd3, bcd2, bcd1, bcd0;
  logic [1:0]  disp_mode;
  logic        frame_valid;
  logic        sat;
  logic        si;

  int total = 0;
  int bad   = 0;
  int lat;
  logic [22:0] exp_q[$];
  logic [22:0] prev_out;
  logic        prev_fv;

  always #5 sys_clk = ~sys_clk;

  display_scheduler dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .step_count   (step_count),
    .half_miles   (half_miles),
    .over32_secs  (over32_secs),
    .high_act_secs(high_act_secs),
    .rot_tick     (rot_tick),
    .hold         (hold),
    .sel          (sel),
    .bcd3         (bcd3),
    .bcd2         (bcd2),
    .bcd1         (bcd1),
    .bcd0         (bcd0),
    .disp_mode    (disp_mode),
    .frame_valid  (frame_valid),
    .sat          (sat),
    .si           (si)
  );

  wire [22:0] frame_bits =
    {bcd3, bcd2, bcd1, bcd0, disp_mode, sat};

  function automatic logic [22:0] model(input logic [1:0] m);
    int unsigned v;
    logic s;
    logic [4:0] d3, d2, d1, d0;
    case (m)
      2'd0:    v = step_count;
      2'd1:    v = half_miles >> 1;
      2'd2:    v = over32_secs;
      default: v = high_act_secs;
    endcase
    if (m == 2'd1) begin
      s = v > 99;
      if (s) v = 99;
      d3 = 5'(v / 10);
      d2 = 5'(v % 10);
      d1 = 5'h1F;
      d0 = half_miles[0] ? 5'd5 : 5'd0;
    end else begin
      s = v > 9999;
      if (s) v = 9999;
      d3 = 5'(v / 1000);
      d2 = 5'((v / 100) % 10);
      d1 = 5'((v / 10) % 10);
      d0 = 5'(v % 10);
    end
    return {d3, d2, d1, d0, m, s};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] m);
    exp_q.push_back(model(m));
  endtask

  task automatic wait_frame(input int maxc, output int n);
    n = 0;
    forever begin
      @(negedge sys_clk);
      n++;
      if (frame_valid) break;
      if (n >= maxc) begin
        total++;
        bad++;
        $error("FAIL frame_timeout observed=%0d expected<%0d",
               n, maxc);
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag);
    logic [22:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%0h expected=queued",
             tag, frame_bits);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(frame_bits), 32'(e));
    end
  endtask

  // Displayed values may only move on a frame_valid pulse.
  always @(negedge sys_clk) begin
    if (!reset) begin
      if (!frame_valid) begin
        total++;
        assert (frame_bits === prev_out) else begin
          bad++;
          $error("FAIL hold_out observed=%0h expected=%0h",
                 frame_bits, prev_out);
        end
      end
      if (prev_fv) begin
        total++;
        assert (frame_valid === 1'b0) else begin
          bad++;
          $error("FAIL fv_pulse observed=%0b expected=0",
                 frame_valid);
        end
      end
    end
    prev_out = frame_bits;
    prev_fv  = frame_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=done");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    step_count    = 31'd1234;
    half_miles    = 31'd15;
    over32_secs   = 31'd56;
    high_act_secs = 31'd10000;
    rot_tick      = 1'b0;
    hold          = 1'b1;
    sel           = 2'd0;
    repeat (3) @(negedge sys_clk);
    chk("rst_state", 32'({frame_bits, frame_valid, si}), 0);

    reset = 1'b0;
    push(2'd0);
    wait_frame(40, lat);
    chk("first_lat", lat, 17);
    check_frame("f_1234");
    push(2'd0);
    wait_frame(40, lat);
    chk("period", lat, 16);
    check_frame("f_1234_b");

    step_count = 31'd12000;
    chk("si_pre", 32'(si), 0);
    push(2'd0);
    @(negedge sys_clk);
    chk("si_post", 32'(si), 1);
    wait_frame(40, lat);
    check_frame("f_sat");

    sel = 2'd1;
    wait_frame(40, lat);
    push(2'd1);
    wait_frame(40, lat);
    check_frame("f_hm15");
    half_miles = 31'd400;
    push(2'd1);
    wait_frame(40, lat);
    check_frame("f_hm400");

    sel        = 2'd0;
    half_miles = 31'd15;
    step_count = 31'd1234;
    wait_frame(40, lat);
    hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      repeat (5) @(negedge sys_clk);
      rot_tick = 1'b1;
      push(2'(k % 4));
      @(negedge sys_clk);
      rot_tick = 1'b0;
      wait_frame(30, lat);
      chk("tick_lat", 32'(lat + 1 <= 17), 1);
      check_frame("f_rot");
    end

    repeat (15) @(negedge sys_clk);
    rot_tick = 1'b1;
    push(2'd0);
    @(negedge sys_clk);
    rot_tick = 1'b0;
    chk("fv_commit", 32'(frame_valid), 1);
    check_frame("f_old_mode");
    push(2'd1);
    wait_frame(30, lat);
    chk("next_lat", lat, 16);
    check_frame("f_new_mode");

    hold       = 1'b1;
    sel        = 2'd0;
    step_count = 31'd5678;
    wait_frame(40, lat);
    push(2'd0);
    wait_frame(40, lat);
    check_frame("f_5678");
    repeat (5) @(negedge sys_clk);
    reset = 1'b1;
    @(negedge sys_clk);
    chk("rst_mid", 32'({frame_bits, frame_valid, si}), 0);
    @(negedge sys_clk);
    reset = 1'b0;
    push(2'd0);
    wait_frame(40, lat);
    chk("rst_lat", lat, 17);
    check_frame("f_after_rst");

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
